// File: rtl/uart_rx_ctrl_pkg.sv
// UART receive controller shared definitions.
// Holds the FSM state encoding and default parameter values.
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    SYNC = 2'b01,
    RUN  = 2'b10
  } state_t;

  localparam int DBIT_DEF       = 8;
  localparam int FIFO_W_DEF     = 4;
  localparam int DVSR_W_DEF     = 11;
  localparam int SYNC_TICKS_DEF = 16;
  localparam int TMO_TICKS_DEF  = 640;

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// rx_fifo: first-word-fall-through receive FIFO, 2**FIFO_W entries.
// Ports: clk, reset (async, active-low), wr/w_data, rd/r_data, empty, full.
module rx_fifo
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int FIFO_W = FIFO_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            rd,
  output logic [DBIT-1:0] r_data,
  output logic            empty,
  output logic            full
);

  logic [DBIT-1:0] mem [2**FIFO_W];
  logic [FIFO_W:0] w_ptr;
  logic [FIFO_W:0] r_ptr;
  logic            do_rd;
  logic            do_wr;

  assign empty = (w_ptr == r_ptr);
  assign full  = (w_ptr[FIFO_W] != r_ptr[FIFO_W]) &&
                 (w_ptr[FIFO_W-1:0] == r_ptr[FIFO_W-1:0]);

  // A pop frees the slot in the same cycle, so full+pop+write is legal.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  // Empty reads as zero so r_data needs no storage reset.
  assign r_data = empty ? '0 : mem[r_ptr[FIFO_W-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[w_ptr[FIFO_W-1:0]] <= w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (do_wr) w_ptr <= w_ptr + 1'b1;
      if (do_rd) r_ptr <= r_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick gen, line-sync FSM, rx FIFO, timeout.
// Ports: clk, reset(n), rx_en, dvsr, rx -> s_tick/rx_line/rx_rst to datapath;
// rx_done_tick/rx_dout in; rd_uart/r_data/rx_empty/rx_full/overrun/clr_err,
// timeout_tick.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DBIT       = DBIT_DEF,
  parameter int FIFO_W     = FIFO_W_DEF,
  parameter int DVSR_W     = DVSR_W_DEF,
  parameter int SYNC_TICKS = SYNC_TICKS_DEF,
  parameter int TMO_TICKS  = TMO_TICKS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_en,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx,
  output logic              s_tick,
  output logic              rx_line,
  output logic              rx_rst,
  input  logic              rx_done_tick,
  input  logic [DBIT-1:0]   rx_dout,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              overrun,
  input  logic              clr_err,
  output logic              timeout_tick
);

  localparam int SW = $clog2(SYNC_TICKS + 1);
  localparam int TW = $clog2(TMO_TICKS + 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_TICKS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_TICKS - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TMO_TICKS);

  state_t            state;
  state_t            state_nxt;
  logic [DVSR_W-1:0] tick_cnt;
  logic [SW-1:0]     sync_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              run;
  logic              fifo_wr;
  logic              wr_ok;
  logic              ovr_set;
  logic              tmo_inc;

  assign run = (state == RUN);

  // >= rather than == so a divisor lowered mid-count still wraps promptly.
  assign s_tick = (state != OFF) && (tick_cnt >= dvsr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else if (state == OFF || s_tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + DVSR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= OFF;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      OFF:  if (rx_en) state_nxt = SYNC;
      SYNC: if (s_tick && rx && sync_cnt == SYNC_LAST) state_nxt = RUN;
      RUN:  state_nxt = RUN;
      default: state_nxt = OFF;
    endcase
    if (!rx_en) state_nxt = OFF;
  end

  // Consecutive idle-high ticks; a low sample restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_cnt <= '0;
    else if (state != SYNC) sync_cnt <= '0;
    else if (s_tick) sync_cnt <= rx ? sync_cnt + SW'(1) : '0;
  end

  assign rx_rst  = (state == OFF);
  assign rx_line = run ? rx : 1'b1;

  assign fifo_wr = run && rx_done_tick;
  assign ovr_set = fifo_wr && rx_full && !rd_uart;
  assign wr_ok   = fifo_wr && !ovr_set;

  rx_fifo #(
    .DBIT   (DBIT),
    .FIFO_W (FIFO_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (fifo_wr),
    .w_data (rx_dout),
    .rd     (rd_uart),
    .r_data (r_data),
    .empty  (rx_empty),
    .full   (rx_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (clr_err) overrun <= 1'b0;
  end

  assign tmo_inc = run && s_tick && !rx_empty && (tmo_cnt != TMO_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt      <= '0;
      timeout_tick <= 1'b0;
    end else begin
      timeout_tick <= tmo_inc && !wr_ok && (tmo_cnt == TMO_LAST);
      if (!run || wr_ok) tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl with a FIFO scoreboard queue.
// Checks tick timing, line sync, FIFO order/overrun, timeout, disable, reset.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_en;
  logic [10:0] dvsr;
  logic        rx;
  logic        s_tick;
  logic        rx_line;
  logic        rx_rst;
  logic        rx_done_tick;
  logic [7:0]  rx_dout;
  logic        rd_uart;
  logic [7:0]  r_data;
  logic        rx_empty;
  logic        rx_full;
  logic        overrun;
  logic        clr_err;
  logic        timeout_tick;

  int checks   = 0;
  int failures = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rx_en        (rx_en),
    .dvsr         (dvsr),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_line      (rx_line),
    .rx_rst       (rx_rst),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rd_uart      (rd_uart),
    .r_data       (r_data),
    .rx_empty     (rx_empty),
    .rx_full      (rx_full),
    .overrun      (overrun),
    .clr_err      (clr_err),
    .timeout_tick (timeout_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for s_tick, present rxv while it is high, then consume it.
  task automatic next_tick(input logic rxv, output int cyc);
    cyc = 0;
    while (!s_tick && cyc < 200) begin
      step();
      cyc++;
    end
    if (!s_tick) check("tick_wait", {31'b0, s_tick}, 1);
    rx = rxv;
    step();
    rx = 1'b1;
  endtask

  // A brief low on rx shows through rx_line only in RUN.
  task automatic probe(input string tag, input logic exp);
    rx = 1'b0;
    #1;
    check(tag, {31'b0, rx_line}, {31'b0, exp});
    rx = 1'b1;
  endtask

  task automatic write(input logic [7:0] b, input logic rd);
    rx_done_tick = 1'b1;
    rx_dout      = b;
    rd_uart      = rd;
    step();
    rx_done_tick = 1'b0;
    rd_uart      = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = q.pop_front();
    check(tag, {24'b0, r_data}, {24'b0, e});
    rd_uart = 1'b1;
    step();
    rd_uart = 1'b0;
  endtask

  initial begin
    int cyc;
    int n;
    int pulses;
    reset = 1'b0;
    rx_en = 1'b0;
    dvsr = 11'd9;
    rx = 1'b1;
    rx_done_tick = 1'b0;
    rx_dout = '0;
    rd_uart = 1'b0;
    clr_err = 1'b0;
    step();
    step();
    check("rst_s_tick", {31'b0, s_tick}, 0);
    check("rst_rx_line", {31'b0, rx_line}, 1);
    check("rst_rx_rst", {31'b0, rx_rst}, 1);
    check("rst_empty", {31'b0, rx_empty}, 1);
    check("rst_full", {31'b0, rx_full}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    check("rst_timeout", {31'b0, timeout_tick}, 0);
    check("rst_r_data", {24'b0, r_data}, 0);

    reset = 1'b1;
    step();
    rx_en = 1'b1;
    step();
    check("sync_rx_rst", {31'b0, rx_rst}, 0);
    for (int i = 1; i <= 16; i++) begin
      next_tick(1'b1, cyc);
      if (i == 2) check("tick_period_9", cyc + 1, 10);
      if (i == 15) probe("sync15_line", 1'b1);
      if (i == 16) probe("sync16_run", 1'b0);
    end

    rx_en = 1'b0;
    step();
    check("off_rx_rst", {31'b0, rx_rst}, 1);
    dvsr = 11'd0;
    rx_en = 1'b1;
    step();
    for (int i = 1; i <= 26; i++) begin
      next_tick((i == 10) ? 1'b0 : 1'b1, cyc);
      if (i == 2) check("tick_period_0", cyc + 1, 1);
      if (i == 25) probe("resync25_line", 1'b1);
      if (i == 26) probe("resync26_run", 1'b0);
    end

    for (int i = 0; i <= 16; i++) begin
      if (i == 16) begin
        check("fill_full", {31'b0, rx_full}, 1);
        check("fill_no_ovr", {31'b0, overrun}, 0);
      end
      write(8'(i), 1'b0);
      if (i < 16) q.push_back(8'(i));
    end
    check("overrun_set", {31'b0, overrun}, 1);
    check("overrun_full", {31'b0, rx_full}, 1);

    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_err", {31'b0, overrun}, 0);

    check("simul_head", {24'b0, r_data}, {24'b0, q.pop_front()});
    write(8'h77, 1'b1);
    q.push_back(8'h77);
    check("simul_no_ovr", {31'b0, overrun}, 0);
    check("simul_full", {31'b0, rx_full}, 1);
    check("simul_adv", {24'b0, r_data}, {24'b0, q[0]});

    clr_err = 1'b1;
    write(8'h99, 1'b0);
    clr_err = 1'b0;
    check("set_wins", {31'b0, overrun}, 1);

    while (q.size() > 0) pop_check("drain");
    check("drain_empty", {31'b0, rx_empty}, 1);
    check("drain_r_data", {24'b0, r_data}, 0);

    rd_uart = 1'b1;
    step();
    rd_uart = 1'b0;
    check("pop_empty", {31'b0, rx_empty}, 1);
    write(8'h3C, 1'b0);
    q.push_back(8'h3C);
    check("fwft_empty", {31'b0, rx_empty}, 0);
    pop_check("fwft_data");

    write(8'hA5, 1'b0);
    q.push_back(8'hA5);
    n = 1;
    while (!timeout_tick && n < 2000) begin
      step();
      n++;
    end
    check("tmo_latency", n, 641);
    step();
    check("tmo_pulse1", {31'b0, timeout_tick}, 0);
    pulses = 0;
    for (int i = 0; i < 700; i++) begin
      if (timeout_tick) pulses++;
      step();
    end
    check("tmo_saturate", pulses, 0);

    write(8'h5A, 1'b0);
    q.push_back(8'h5A);
    rx_en = 1'b0;
    step();
    check("dis_rx_rst", {31'b0, rx_rst}, 1);
    write(8'hEE, 1'b0);
    check("dis_overrun", {31'b0, overrun}, 1);
    check("dis_timeout", {31'b0, timeout_tick}, 0);
    pop_check("dis_keep0");
    pop_check("dis_keep1");
    check("dis_ignored", {31'b0, rx_empty}, 1);

    rx_en = 1'b1;
    repeat (5) step();
    reset = 1'b0;
    #1;
    check("mid_rst_rx_rst", {31'b0, rx_rst}, 1);
    check("mid_rst_s_tick", {31'b0, s_tick}, 0);
    check("mid_rst_overrun", {31'b0, overrun}, 0);
    step();
    reset = 1'b1;
    rx_done_tick = 1'b1;
    rx_dout = 8'h11;
    repeat (5) step();
    rx_done_tick = 1'b0;
    step();
    check("post_rst_empty", {31'b0, rx_empty}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DBIT, default 8, data bits per frame; sets FIFO word width.
REQ-002 Parameter FIFO_W, default 4, log2 of FIFO depth (16 entries).
REQ-003 Parameter DVSR_W, default 11, width of the baud divisor.
REQ-004 Parameter SYNC_TICKS, default 16, consecutive idle-high s_ticks required before bytes are accepted.
REQ-005 Parameter TMO_TICKS, default 640, inter-byte idle s_ticks before timeout_tick.
REQ-006 clk  in  1  single system clock, all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 rx_en  in  1  level; 1 = receiver enabled.
REQ-009 dvsr  in  DVSR_W  baud divisor; s_tick period = dvsr+1 clk cycles.
REQ-010 rx  in  1  serial line (pre-synchronised).
REQ-011 s_tick  out  1  16x oversample tick to the uart_rx datapath.
REQ-012 rx_line  out  1  line fed to the uart_rx datapath.
REQ-013 rx_rst  out  1  active-high reset to the uart_rx datapath.
REQ-014 rx_done_tick  in  1  frame-complete pulse from the datapath.
REQ-015 rx_dout  in  DBIT  received byte from the datapath.
REQ-016 rd_uart  in  1  one-cycle pop request.
REQ-017 r_data  out  DBIT  FIFO head (first-word-fall-through), valid when rx_empty=0.
REQ-018 rx_empty / rx_full  out  1 each  FIFO status.
REQ-019 overrun  out  1  sticky: byte dropped on full FIFO.
REQ-020 clr_err  in  1  one-cycle clear of overrun.
REQ-021 timeout_tick  out  1  one-cycle pulse on inter-byte timeout.

Function
REQ-022 Tick generator SHALL count 0..dvsr, pulse s_tick for one cycle at count==dvsr, then wrap to 0; dvsr=0 gives s_tick every cycle; counter held at 0 and s_tick=0 in state OFF.
REQ-023 FSM states OFF, SYNC, RUN; OFF -> SYNC when rx_en=1; SYNC -> RUN after SYNC_TICKS consecutive s_ticks with rx=1 (any s_tick with rx=0 restarts the count); any state -> OFF when rx_en=0, effective next cycle.
REQ-024 rx_rst SHALL be 1 in OFF, 0 otherwise; rx_line SHALL equal rx in RUN, constant 1 in OFF and SYNC.
REQ-025 In RUN, rx_done_tick with FIFO not full SHALL write rx_dout; with FIFO full and no same-cycle pop, the byte is dropped and overrun set next cycle.
REQ-026 rx_done_tick outside RUN SHALL be ignored.
REQ-027 Simultaneous write and pop on full FIFO SHALL both succeed; count unchanged.
REQ-028 Pop on empty FIFO SHALL be ignored; pointers unchanged.
REQ-029 Write into empty FIFO SHALL make r_data valid and rx_empty=0 on the next cycle.
REQ-030 clr_err together with a new overrun event SHALL leave overrun=1 (set wins).
REQ-031 Timeout counter SHALL clear on every accepted write, increment on each s_tick in RUN while FIFO non-empty, pulse timeout_tick once on reaching TMO_TICKS, then saturate without further pulses until the next write.
REQ-032 Leaving RUN SHALL clear the timeout counter; FIFO contents and overrun SHALL be preserved across disable.

Reset
REQ-033 On reset=0: state OFF, tick/sync/timeout counters 0, FIFO pointers 0.
REQ-034 Reset outputs: s_tick=0, rx_line=1, rx_rst=1, rx_empty=1, rx_full=0, overrun=0, timeout_tick=0, r_data=0.
REQ-035 Reset mid-frame or mid-sync SHALL discard all state; no byte is written on release.

Structure
REQ-036 Shared package SHALL hold FSM state encoding (OFF=2'b00, SYNC=2'b01, RUN=2'b10) and parameter defaults.
REQ-037 The FIFO SHALL be one sub-module, rx_fifo (parameters DBIT, FIFO_W); tick generator and FSM stay inline.

Verification
REQ-038 dvsr=9 enabled -> s_tick every 10 clk; dvsr=0 -> every clk.
REQ-039 rx_en=1, rx held 1 -> RUN after exactly 16 s_ticks; rx=0 at tick 10 -> count restarts, RUN after 26 total.
REQ-040 RUN, 17 rx_done_ticks with bytes 0x00..0x10, no pops -> rx_full after 16, 0x10 dropped, overrun=1; pops return 0x00..0x0F in order.
REQ-041 Full FIFO, rx_done_tick and rd_uart same cycle -> no overrun, rx_full stays 1, head advances.
REQ-042 One byte 0xA5 written, no further traffic, TMO_TICKS=640 -> exactly one timeout_tick 640 s_ticks later.
REQ-043 rx_en=0 mid-frame -> rx_rst=1 next cycle, later rx_done_tick ignored, FIFO contents intact.
